// File: rtl/branch_predictor_if.sv
// IF/EX-facing bundle of the branch predictor: fetch lookup, resolved-branch update, flush, perf counters.
// master = pipeline side, slave = predictor side.
interface branch_predictor_if #(
    parameter int CNT_WIDTH = 32
);
    logic [31:0]          lookup_pc;
    logic                 pred_hit;
    logic                 pred_taken;
    logic [31:0]          pred_target;
    logic                 upd_valid;
    logic [31:0]          upd_pc;
    logic                 upd_taken;
    logic [31:0]          upd_target;
    logic                 upd_mispredict;
    logic                 flush_all;
    logic [CNT_WIDTH-1:0] branch_count;
    logic [CNT_WIDTH-1:0] mispredict_count;

    modport master (
        output lookup_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict, flush_all,
        input  pred_hit, pred_taken, pred_target, branch_count, mispredict_count
    );

    modport slave (
        input  lookup_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict, flush_all,
        output pred_hit, pred_taken, pred_target, branch_count, mispredict_count
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BHT + BTB: zero-latency combinational lookup, updates land on the next clk edge.
// No backpressure: one lookup and at most one resolved-branch update accepted every cycle.
module branch_predictor #(
    parameter int ENTRIES   = 16,
    parameter int TAG_BITS  = 8,
    parameter int CNT_WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    branch_predictor_if.slave  bp
);
    localparam int IDX_W = $clog2(ENTRIES);

    logic [ENTRIES-1:0]  r_valid;
    logic [TAG_BITS-1:0] r_tag    [ENTRIES];
    logic [31:0]         r_target [ENTRIES];
    logic [1:0]          r_ctr    [ENTRIES];
    logic [CNT_WIDTH-1:0] r_branch_count;
    logic [CNT_WIDTH-1:0] r_mispredict_count;

    logic [IDX_W-1:0]    w_lk_idx;
    logic [TAG_BITS-1:0] w_lk_tag;
    logic [IDX_W-1:0]    w_up_idx;
    logic [TAG_BITS-1:0] w_up_tag;
    logic                w_lk_hit;
    logic                w_up_hit;
    logic                w_unused_pc_bits;

    assign w_lk_idx = bp.lookup_pc[IDX_W+1:2];
    assign w_lk_tag = bp.lookup_pc[IDX_W+1+TAG_BITS:IDX_W+2];
    assign w_up_idx = bp.upd_pc[IDX_W+1:2];
    assign w_up_tag = bp.upd_pc[IDX_W+1+TAG_BITS:IDX_W+2];
    // Byte-offset and above-tag PC bits take no part in indexing or matching.
    assign w_unused_pc_bits = ^{bp.lookup_pc, bp.upd_pc};

    assign w_lk_hit = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
    assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);

    assign bp.pred_hit         = w_lk_hit;
    assign bp.pred_taken       = w_lk_hit && r_ctr[w_lk_idx][1];
    assign bp.pred_target      = (w_lk_hit && r_ctr[w_lk_idx][1]) ? r_target[w_lk_idx]
                                                                  : bp.lookup_pc + 32'd4;
    assign bp.branch_count     = r_branch_count;
    assign bp.mispredict_count = r_mispredict_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid            <= '0;
            r_branch_count     <= '0;
            r_mispredict_count <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= '0;
            end
        end else begin
            // Counters keep running through a flush; both stick at all-ones.
            if (bp.upd_valid && (r_branch_count != '1))
                r_branch_count <= r_branch_count + 1'b1;
            if (bp.upd_valid && bp.upd_mispredict && (r_mispredict_count != '1))
                r_mispredict_count <= r_mispredict_count + 1'b1;

            if (bp.flush_all) begin
                r_valid <= '0;
            end else if (bp.upd_valid) begin
                if (w_up_hit) begin
                    if (bp.upd_taken) begin
                        if (r_ctr[w_up_idx] != 2'b11)
                            r_ctr[w_up_idx] <= r_ctr[w_up_idx] + 2'b01;
                        r_target[w_up_idx] <= bp.upd_target;
                    end else if (r_ctr[w_up_idx] != 2'b00) begin
                        r_ctr[w_up_idx] <= r_ctr[w_up_idx] - 2'b01;
                    end
                end else if (bp.upd_taken) begin
                    // Taken miss evicts whatever occupied the slot, starting weakly taken.
                    r_valid[w_up_idx]  <= 1'b1;
                    r_tag[w_up_idx]    <= w_up_tag;
                    r_target[w_up_idx] <= bp.upd_target;
                    r_ctr[w_up_idx]    <= 2'b10;
                end
            end
        end
    end
endmodule
